// File: rtl/ce_issue_ctl.sv
// CorExtend issue control: tracks the UDI instruction through E, M and W,
// applies CE halt with a timeout, and produces GPR writeback and RI pulses.
module ce_issue_ctl #(
  parameter int HALT_LIMIT = 255
) (
  input  logic        CLK,
  input  logic        RESET_D1_R,
  input  logic        CFG_CEENBL,
  input  logic        STALL_IN,
  input  logic        XCPN_M,
  input  logic        ISSUE_S,
  input  logic [11:0] OP_S,
  input  logic        INSTM32_S_N,
  input  logic [31:0] AOP_S,
  input  logic [31:0] BOP_S,
  input  logic [4:0]  RD_S,
  input  logic [31:0] CE_RES_E,
  input  logic        CE_SEL_E_R,
  input  logic        CE_HALT_E_R_C,
  output logic [11:0] CEI_OP_S_R,
  output logic        CEI_INSTM32_S_R_N,
  output logic [31:0] CEI_AOP_E_R,
  output logic [31:0] CEI_BOP_E_R,
  output logic        CEI_CEHOLD,
  output logic        CEI_XCPN_M,
  output logic        CE_STALL,
  output logic        WB_VLD_W,
  output logic [4:0]  WB_RD_W,
  output logic [31:0] WB_DATA_W,
  output logic        UDI_RI_E,
  output logic        CE_TMO,
  output logic        CE_BUSY
);

  localparam logic [7:0] LP_LIMIT = 8'(HALT_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [7:0]  r_hcnt;
  logic [11:0] r_op_e;
  logic        r_instm32_e_n;
  logic [31:0] r_aop_e;
  logic [31:0] r_bop_e;
  logic [4:0]  r_rd_e;
  logic        r_valid_m;
  logic [31:0] r_data_m;
  logic [4:0]  r_rd_m;
  logic        r_wb_vld;
  logic [4:0]  r_wb_rd;
  logic [31:0] r_wb_data;
  logic        r_udi_ri;
  logic        r_tmo;

  logic        w_valid_e;
  logic        w_at_limit;
  logic        w_halt_e;
  logic        w_tmo;
  logic        w_adv;
  logic        w_issue_ok;
  logic        w_wb_fire;

  // Once hcnt reaches the limit the CE halt is ignored and the instruction
  // is forced out of E as a timeout.
  assign w_valid_e  = (r_state != ST_IDLE);
  assign w_at_limit = (r_hcnt >= LP_LIMIT);
  assign w_halt_e   = w_valid_e & CE_HALT_E_R_C & ~w_at_limit;
  assign w_tmo      = w_valid_e & CE_HALT_E_R_C & w_at_limit;
  assign w_adv      = ~STALL_IN & ~w_halt_e;
  assign w_issue_ok = ISSUE_S & CFG_CEENBL;
  assign w_wb_fire  = w_adv & r_valid_m & ~XCPN_M;

  always_comb begin
    w_state_nxt = r_state;
    if (w_adv) begin
      w_state_nxt = w_issue_ok ? ST_EXEC : ST_IDLE;
    end else if (w_halt_e) begin
      w_state_nxt = ST_HALT;
    end else if (r_state == ST_HALT) begin
      w_state_nxt = ST_EXEC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET_D1_R) begin
      r_state       <= ST_IDLE;
      r_hcnt        <= 8'd0;
      r_op_e        <= 12'd0;
      r_instm32_e_n <= 1'b1;
      r_aop_e       <= 32'd0;
      r_bop_e       <= 32'd0;
      r_rd_e        <= 5'd0;
      r_valid_m     <= 1'b0;
      r_data_m      <= 32'd0;
      r_rd_m        <= 5'd0;
      r_wb_vld      <= 1'b0;
      r_wb_rd       <= 5'd0;
      r_wb_data     <= 32'd0;
      r_udi_ri      <= 1'b0;
      r_tmo         <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_adv) begin
        r_hcnt        <= 8'd0;
        r_op_e        <= OP_S;
        r_instm32_e_n <= INSTM32_S_N;
        r_aop_e       <= AOP_S;
        r_bop_e       <= BOP_S;
        r_rd_e        <= RD_S;
        r_data_m      <= CE_RES_E;
        r_rd_m        <= r_rd_e;
      end else if (w_halt_e) begin
        r_hcnt <= r_hcnt + 8'd1;
      end

      // An M-stage kill wins over both hold and advance.
      if (XCPN_M) begin
        r_valid_m <= 1'b0;
      end else if (w_adv) begin
        r_valid_m <= w_valid_e & CE_SEL_E_R & ~w_tmo;
      end

      r_wb_vld <= w_wb_fire;
      if (w_wb_fire) begin
        r_wb_rd   <= r_rd_m;
        r_wb_data <= r_data_m;
      end

      r_udi_ri <= w_adv & ISSUE_S & ~CFG_CEENBL;
      r_tmo    <= w_adv & w_tmo;
    end
  end

  assign CEI_OP_S_R        = r_op_e;
  assign CEI_INSTM32_S_R_N = r_instm32_e_n;
  assign CEI_AOP_E_R       = r_aop_e;
  assign CEI_BOP_E_R       = r_bop_e;
  assign CEI_CEHOLD        = ~w_adv;
  assign CEI_XCPN_M        = XCPN_M & r_valid_m;
  assign CE_STALL          = w_halt_e;
  assign WB_VLD_W          = r_wb_vld;
  assign WB_RD_W           = r_wb_rd;
  assign WB_DATA_W         = r_wb_data;
  assign UDI_RI_E          = r_udi_ri;
  assign CE_TMO            = r_tmo;
  assign CE_BUSY           = w_valid_e | r_valid_m;

endmodule

// File: tb/tb_ce_issue_ctl.sv
// Directed bench for ce_issue_ctl: instance a uses the default halt limit,
// instance b uses HALT_LIMIT=3; both share the same stimulus.
module tb_ce_issue_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg;
  logic        stall_in;
  logic        xcpn_m;
  logic        issue_s;
  logic [11:0] op_s;
  logic        instm32_n;
  logic [31:0] aop_s;
  logic [31:0] bop_s;
  logic [4:0]  rd_s;
  logic [31:0] ce_res;
  logic        ce_sel;
  logic        ce_halt;

  logic [11:0] a_op,   b_op;
  logic        a_i32n, b_i32n;
  logic [31:0] a_aop,  b_aop;
  logic [31:0] a_bop,  b_bop;
  logic        a_hold, b_hold;
  logic        a_xcpn, b_xcpn;
  logic        a_stall, b_stall;
  logic        a_wbv,  b_wbv;
  logic [4:0]  a_wbr,  b_wbr;
  logic [31:0] a_wbd,  b_wbd;
  logic        a_ri,   b_ri;
  logic        a_tmo,  b_tmo;
  logic        a_busy, b_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ce_issue_ctl u_a (
    .CLK(clk), .RESET_D1_R(rst), .CFG_CEENBL(cfg), .STALL_IN(stall_in), .XCPN_M(xcpn_m),
    .ISSUE_S(issue_s), .OP_S(op_s), .INSTM32_S_N(instm32_n), .AOP_S(aop_s), .BOP_S(bop_s),
    .RD_S(rd_s), .CE_RES_E(ce_res), .CE_SEL_E_R(ce_sel), .CE_HALT_E_R_C(ce_halt),
    .CEI_OP_S_R(a_op), .CEI_INSTM32_S_R_N(a_i32n), .CEI_AOP_E_R(a_aop), .CEI_BOP_E_R(a_bop),
    .CEI_CEHOLD(a_hold), .CEI_XCPN_M(a_xcpn), .CE_STALL(a_stall), .WB_VLD_W(a_wbv),
    .WB_RD_W(a_wbr), .WB_DATA_W(a_wbd), .UDI_RI_E(a_ri), .CE_TMO(a_tmo), .CE_BUSY(a_busy)
  );

  ce_issue_ctl #(.HALT_LIMIT(3)) u_b (
    .CLK(clk), .RESET_D1_R(rst), .CFG_CEENBL(cfg), .STALL_IN(stall_in), .XCPN_M(xcpn_m),
    .ISSUE_S(issue_s), .OP_S(op_s), .INSTM32_S_N(instm32_n), .AOP_S(aop_s), .BOP_S(bop_s),
    .RD_S(rd_s), .CE_RES_E(ce_res), .CE_SEL_E_R(ce_sel), .CE_HALT_E_R_C(ce_halt),
    .CEI_OP_S_R(b_op), .CEI_INSTM32_S_R_N(b_i32n), .CEI_AOP_E_R(b_aop), .CEI_BOP_E_R(b_bop),
    .CEI_CEHOLD(b_hold), .CEI_XCPN_M(b_xcpn), .CE_STALL(b_stall), .WB_VLD_W(b_wbv),
    .WB_RD_W(b_wbr), .WB_DATA_W(b_wbd), .UDI_RI_E(b_ri), .CE_TMO(b_tmo), .CE_BUSY(b_busy)
  );

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cfg = 1'b1; stall_in = 1'b0; xcpn_m = 1'b0; issue_s = 1'b0;
    op_s = 12'd0; instm32_n = 1'b1; aop_s = 32'd0; bop_s = 32'd0; rd_s = 5'd0;
    ce_res = 32'd0; ce_sel = 1'b0; ce_halt = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic issue(input logic [11:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    issue_s = 1'b1; op_s = op; instm32_n = 1'b0; aop_s = a; bop_s = b; rd_s = rd;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    issue(12'h0C1, 32'd5, 32'd7, 5'd3);
    cyc();
    cyc();
    #1;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", a_busy); end checks++;
    if (a_wbv !== 1'b0) begin failures++; $display("FAIL reset_wb_vld got=%0h exp=0", a_wbv); end checks++;
    if (a_ri !== 1'b0 || a_tmo !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%0h/%0h exp=0/0", a_ri, a_tmo); end checks++;
    if (a_op !== 12'd0) begin failures++; $display("FAIL reset_op got=%0h exp=0", a_op); end checks++;
    if (a_aop !== 32'd0 || a_bop !== 32'd0) begin failures++; $display("FAIL reset_ops got=%0h/%0h exp=0/0", a_aop, a_bop); end checks++;
    if (a_wbd !== 32'd0) begin failures++; $display("FAIL reset_wb_data got=%0h exp=0", a_wbd); end checks++;
    if (a_i32n !== 1'b1) begin failures++; $display("FAIL reset_instm32 got=%0h exp=1", a_i32n); end checks++;
    if (a_stall !== 1'b0 || a_hold !== 1'b0) begin failures++; $display("FAIL reset_hold got=%0h/%0h exp=0/0", a_stall, a_hold); end checks++;
    rst = 1'b0;
    clear_inputs();
    cyc();
  endtask

  task automatic test_basic();
    issue(12'h0C1, 32'd5, 32'd7, 5'd3);
    cyc();
    issue_s = 1'b0; op_s = 12'hFFF; instm32_n = 1'b1; aop_s = 32'hDEAD; bop_s = 32'hBEEF; rd_s = 5'd31;
    ce_sel = 1'b1; ce_res = 32'd35;
    #1;
    if (a_op !== 12'h0C1 || a_i32n !== 1'b0) begin failures++; $display("FAIL basic_e_op got=%0h/%0h exp=0c1/0", a_op, a_i32n); end checks++;
    if (a_aop !== 32'd5 || a_bop !== 32'd7) begin failures++; $display("FAIL basic_e_ops got=%0h/%0h exp=5/7", a_aop, a_bop); end checks++;
    if (a_busy !== 1'b1) begin failures++; $display("FAIL basic_busy_e got=%0h exp=1", a_busy); end checks++;
    cyc();
    ce_sel = 1'b0; ce_res = 32'd0;
    #1;
    if (a_wbv !== 1'b0 || a_busy !== 1'b1) begin failures++; $display("FAIL basic_m got=%0h/%0h exp=0/1", a_wbv, a_busy); end checks++;
    cyc();
    #1;
    if (a_wbv !== 1'b1) begin failures++; $display("FAIL basic_wb_vld got=%0h exp=1", a_wbv); end checks++;
    if (a_wbr !== 5'd3 || a_wbd !== 32'd35) begin failures++; $display("FAIL basic_wb_dat got=%0h/%0h exp=3/23", a_wbr, a_wbd); end checks++;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_idle got=%0h exp=0", a_busy); end checks++;
    cyc();
    if (a_wbv !== 1'b0) begin failures++; $display("FAIL basic_wb_once got=%0h exp=0", a_wbv); end checks++;
  endtask

  task automatic test_no_sel();
    issue(12'h0C2, 32'd1, 32'd2, 5'd6);
    cyc();
    clear_inputs();
    cyc();
    cyc();
    if (a_wbv !== 1'b0) begin failures++; $display("FAIL nosel_wb got=%0h exp=0", a_wbv); end checks++;
    cyc();
  endtask

  task automatic test_halt();
    issue(12'h123, 32'hA, 32'hB, 5'd7);
    cyc();
    issue_s = 1'b0; op_s = 12'h555; aop_s = 32'h1; bop_s = 32'h2;
    ce_sel = 1'b1; ce_res = 32'h99;
    for (int c = 1; c <= 4; c++) begin
      ce_halt = 1'b1;
      #1;
      if (a_stall !== 1'b1 || a_hold !== 1'b1) begin failures++; $display("FAIL halt_stall c=%0d got=%0h/%0h exp=1/1", c, a_stall, a_hold); end checks++;
      if (a_op !== 12'h123 || a_aop !== 32'hA || a_bop !== 32'hB) begin failures++; $display("FAIL halt_e_stable c=%0d got=%0h/%0h/%0h exp=123/a/b", c, a_op, a_aop, a_bop); end checks++;
      if (a_tmo !== 1'b0) begin failures++; $display("FAIL halt_tmo c=%0d got=%0h exp=0", c, a_tmo); end checks++;
      cyc();
    end
    ce_halt = 1'b0;
    #1;
    if (a_stall !== 1'b0) begin failures++; $display("FAIL halt_release got=%0h exp=0", a_stall); end checks++;
    cyc();
    ce_sel = 1'b0;
    cyc();
    if (a_wbv !== 1'b1 || a_wbr !== 5'd7 || a_wbd !== 32'h99) begin failures++; $display("FAIL halt_wb got=%0h/%0h/%0h exp=1/7/99", a_wbv, a_wbr, a_wbd); end checks++;
    if (a_tmo !== 1'b0) begin failures++; $display("FAIL halt_no_tmo got=%0h exp=0", a_tmo); end checks++;
    cyc();
  endtask

  task automatic test_timeout();
    do_reset();
    issue(12'h0C3, 32'd3, 32'd4, 5'd8);
    cyc();
    issue_s = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      ce_halt = 1'b1; ce_sel = 1'b1; ce_res = 32'h55;
      #1;
      if (b_stall !== (c <= 3)) begin failures++; $display("FAIL tmo_b_stall c=%0d got=%0h exp=%0h", c, b_stall, (c <= 3)); end checks++;
      if (b_tmo !== (c == 5)) begin failures++; $display("FAIL tmo_pulse c=%0d got=%0h exp=%0h", c, b_tmo, (c == 5)); end checks++;
      if (b_wbv !== 1'b0) begin failures++; $display("FAIL tmo_no_wb c=%0d got=%0h exp=0", c, b_wbv); end checks++;
      if (a_stall !== 1'b1) begin failures++; $display("FAIL tmo_a_stall c=%0d got=%0h exp=1", c, a_stall); end checks++;
      cyc();
    end
    ce_halt = 1'b0; ce_sel = 1'b0;
    #1;
    if (a_stall !== 1'b0 || b_busy !== 1'b0) begin failures++; $display("FAIL tmo_after got=%0h/%0h exp=0/0", a_stall, b_busy); end checks++;
    cyc();
    issue(12'h0AA, 32'd1, 32'd1, 5'd9);
    cyc();
    issue_s = 1'b0; ce_halt = 1'b1;
    #1;
    if (b_stall !== 1'b1) begin failures++; $display("FAIL tmo_hcnt_cleared got=%0h exp=1", b_stall); end checks++;
    cyc();
    ce_halt = 1'b0; ce_sel = 1'b1; ce_res = 32'h77;
    cyc();
    ce_sel = 1'b0;
    cyc();
    if (b_wbv !== 1'b1 || b_wbr !== 5'd9 || b_wbd !== 32'h77) begin failures++; $display("FAIL tmo_resume_wb got=%0h/%0h/%0h exp=1/9/77", b_wbv, b_wbr, b_wbd); end checks++;
    cyc();
  endtask

  task automatic test_xcpn();
    do_reset();
    xcpn_m = 1'b1;
    #1;
    if (a_xcpn !== 1'b0) begin failures++; $display("FAIL xcpn_idle got=%0h exp=0", a_xcpn); end checks++;
    xcpn_m = 1'b0;
    issue(12'h0C4, 32'd1, 32'd2, 5'd10);
    cyc();
    issue_s = 1'b0; ce_sel = 1'b1; ce_res = 32'h42;
    cyc();
    ce_sel = 1'b0; xcpn_m = 1'b1;
    #1;
    if (a_xcpn !== 1'b1) begin failures++; $display("FAIL xcpn_same_cycle got=%0h exp=1", a_xcpn); end checks++;
    cyc();
    xcpn_m = 1'b0;
    #1;
    if (a_wbv !== 1'b0 || a_xcpn !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL xcpn_killed got=%0h/%0h/%0h exp=0/0/0", a_wbv, a_xcpn, a_busy); end checks++;
    issue(12'h0C5, 32'd1, 32'd2, 5'd11);
    cyc();
    issue_s = 1'b0; ce_sel = 1'b1; ce_res = 32'h43;
    cyc();
    ce_sel = 1'b0; stall_in = 1'b1; xcpn_m = 1'b1;
    #1;
    if (a_xcpn !== 1'b1 || a_hold !== 1'b1 || a_stall !== 1'b0) begin failures++; $display("FAIL xcpn_stalled got=%0h/%0h/%0h exp=1/1/0", a_xcpn, a_hold, a_stall); end checks++;
    cyc();
    stall_in = 1'b0; xcpn_m = 1'b0;
    #1;
    if (a_busy !== 1'b0) begin failures++; $display("FAIL xcpn_stalled_clear got=%0h exp=0", a_busy); end checks++;
    cyc();
    if (a_wbv !== 1'b0) begin failures++; $display("FAIL xcpn_stalled_wb got=%0h exp=0", a_wbv); end checks++;
  endtask

  task automatic test_udi_ri();
    do_reset();
    cfg = 1'b0; stall_in = 1'b1;
    issue(12'h0C6, 32'd1, 32'd2, 5'd12);
    cyc();
    #1;
    if (a_ri !== 1'b0) begin failures++; $display("FAIL ri_stalled got=%0h exp=0", a_ri); end checks++;
    stall_in = 1'b0;
    cyc();
    issue_s = 1'b0;
    #1;
    if (a_ri !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL ri_pulse got=%0h/%0h exp=1/0", a_ri, a_busy); end checks++;
    cyc();
    if (a_ri !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL ri_once got=%0h/%0h exp=0/0", a_ri, a_busy); end checks++;
    cfg = 1'b1;
  endtask

  task automatic test_stall_and_halt();
    do_reset();
    issue(12'h0C7, 32'd1, 32'd2, 5'd13);
    cyc();
    issue_s = 1'b0; ce_halt = 1'b1; stall_in = 1'b1;
    #1;
    if (a_stall !== 1'b1 || b_stall !== 1'b1 || a_hold !== 1'b1) begin failures++; $display("FAIL both_c1 got=%0h/%0h/%0h exp=1/1/1", a_stall, b_stall, a_hold); end checks++;
    cyc();
    cyc();
    stall_in = 1'b0;
    #1;
    if (b_stall !== 1'b1 || b_hold !== 1'b1) begin failures++; $display("FAIL both_c3 got=%0h/%0h exp=1/1", b_stall, b_hold); end checks++;
    cyc();
    if (b_stall !== 1'b0 || a_stall !== 1'b1) begin failures++; $display("FAIL both_c4_count got=%0h/%0h exp=0/1", b_stall, a_stall); end checks++;
    cyc();
    ce_halt = 1'b0; stall_in = 1'b1;
    #1;
    if (b_tmo !== 1'b1) begin failures++; $display("FAIL both_tmo got=%0h exp=1", b_tmo); end checks++;
    if (a_stall !== 1'b0 || a_hold !== 1'b1) begin failures++; $display("FAIL both_hold_stall got=%0h/%0h exp=0/1", a_stall, a_hold); end checks++;
    cyc();
    stall_in = 1'b0;
    #1;
    if (a_hold !== 1'b0) begin failures++; $display("FAIL both_release got=%0h exp=0", a_hold); end checks++;
    cyc();
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      issue_s = (c < 3); op_s = 12'h0C8; instm32_n = 1'b0; rd_s = 5'(c + 1);
      ce_sel = (c >= 1 && c <= 3); ce_res = 32'(c * 10);
      #1;
      if (a_wbv !== (c >= 3 && c <= 5)) begin failures++; $display("FAIL b2b_vld c=%0d got=%0h exp=%0h", c, a_wbv, (c >= 3 && c <= 5)); end checks++;
      if (c >= 3 && c <= 5) begin
        if (a_wbr !== 5'(c - 2) || a_wbd !== 32'((c - 2) * 10)) begin failures++; $display("FAIL b2b_dat c=%0d got=%0h/%0h exp=%0h/%0h", c, a_wbr, a_wbd, c - 2, (c - 2) * 10); end checks++;
      end
      cyc();
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_halt();
    do_reset();
    issue(12'h0C9, 32'd1, 32'd2, 5'd4);
    cyc();
    issue(12'h0CA, 32'd3, 32'd4, 5'd5);
    ce_sel = 1'b1; ce_res = 32'h11;
    cyc();
    issue_s = 1'b0; ce_halt = 1'b1; ce_res = 32'h22;
    #1;
    if (a_stall !== 1'b1 || a_busy !== 1'b1) begin failures++; $display("FAIL rsth_pre got=%0h/%0h exp=1/1", a_stall, a_busy); end checks++;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    if (a_busy !== 1'b0 || a_stall !== 1'b0 || a_wbv !== 1'b0) begin failures++; $display("FAIL rsth_state got=%0h/%0h/%0h exp=0/0/0", a_busy, a_stall, a_wbv); end checks++;
    if (a_op !== 12'd0 || a_aop !== 32'd0 || a_bop !== 32'd0 || a_i32n !== 1'b1) begin failures++; $display("FAIL rsth_regs got=%0h/%0h/%0h/%0h exp=0/0/0/1", a_op, a_aop, a_bop, a_i32n); end checks++;
    if (a_ri !== 1'b0 || a_tmo !== 1'b0 || a_wbd !== 32'd0) begin failures++; $display("FAIL rsth_pulses got=%0h/%0h/%0h exp=0/0/0", a_ri, a_tmo, a_wbd); end checks++;
    ce_halt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc();
      if (a_wbv !== 1'b0 || a_busy !== 1'b0) begin failures++; $display("FAIL rsth_after c=%0d got=%0h/%0h exp=0/0", c, a_wbv, a_busy); end checks++;
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    cyc();
    test_reset();
    test_basic();
    test_no_sel();
    test_halt();
    test_timeout();
    test_xcpn();
    test_udi_ri();
    test_stall_and_halt();
    test_back_to_back();
    test_reset_in_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
